// File: rtl/uart_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Word offsets within the register window, compared against a[3:2]
  localparam logic [1:0] TXDATA_OFS  = 2'd0;
  localparam logic [1:0] STATUS_OFS  = 2'd1;
  localparam logic [1:0] BAUDDIV_OFS = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;
  localparam int ST_CNT_W   = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data; simultaneous push and
// pop are both honoured even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, byte FIFO, baud counter
// and LSB-first shifter driving a registered tx line.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'h0000_0400,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DIV_RESET = 16'd9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    ofs;
  logic          wr_txdata, wr_status, wr_baud;
  logic [15:0]   baud_q;
  logic          ovf_q, ovf_set, ovf_clr;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  uart_state_t   state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          bit_end;
  logic          unused_bits;

  function automatic logic [31:0] status_word(input logic b, input logic f,
                                              input logic e, input logic o,
                                              input logic [CW-1:0] c);
    logic [31:0] w;
    w = '0;
    w[ST_BUSY]  = b;
    w[ST_FULL]  = f;
    w[ST_EMPTY] = e;
    w[ST_OVF]   = o;
    w[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(c);
    return w;
  endfunction

  assign ofs         = a[3:2];
  assign hit         = (a[31:4] == BASE[31:4]) && (ofs != 2'd3);
  assign wr_txdata   = we && hit && (ofs == TXDATA_OFS);
  assign wr_status   = we && hit && (ofs == STATUS_OFS);
  assign wr_baud     = we && hit && (ofs == BAUDDIV_OFS);
  assign unused_bits = ^{a[1:0], wd[31:16]};

  // A push into a full FIFO survives only if the FSM pops in the same cycle
  assign ovf_set = wr_txdata && fifo_full && !fifo_pop;
  assign ovf_clr = wr_status && wd[ST_OVF];

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .wdata (wd[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q <= DIV_RESET;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_baud) baud_q <= wd[15:0];
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE) || !fifo_empty;
  assign tx   = tx_q;

  always_comb begin
    rd = '0;
    if (hit) begin
      case (ofs)
        STATUS_OFS:  rd = status_word(busy, fifo_full, fifo_empty, ovf_q, fifo_count);
        BAUDDIV_OFS: rd = {16'h0000, baud_q};
        default:     rd = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign bit_end = (cnt_q == 16'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = baud_q;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          cnt_d   = baud_q;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = baud_q;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            cnt_d    = baud_q;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a line monitor decodes 8N1 frames and compares them
// against a queue of bytes expected from the stores issued by the stimulus.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0400;

  logic        clk = 1'b0;
  logic        reset, we;
  logic [31:0] a, wd, rd;
  logic        hit, tx, busy;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          cur_div = 9;
  int          frames = 0;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  mmio_uart_tx #(.BASE(BASE), .DEPTH(4), .DIV_RESET(16'd9)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .hit   (hit),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int pop_start();
    if (start_q.size() == 0) return -1;
    return start_q.pop_front();
  endfunction

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, output int commit);
    we = 1'b1; a = addr; wd = data;
    @(posedge clk); #1;
    commit = cyc;
    we = 1'b0; a = '0; wd = '0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data, output logic h);
    we = 1'b0; a = addr;
    @(negedge clk);
    data = rd; h = hit;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int t0;
    t0 = cyc;
    while (frames < n && (cyc - t0) < budget) @(negedge clk);
    chk("frame_wait", 32'(frames >= n), 32'd1);
  endtask

  // Line monitor: samples every cycle of each frame at the falling edge
  initial begin : monitor
    logic       lvl[10];
    logic [7:0] rx;
    logic       glitch, aborted;
    int         t, s;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        t = cur_div + 1; s = cyc; glitch = 1'b0; aborted = 1'b0;
        for (int k = 0; k < 10; k++) begin
          for (int c = 0; c < t; c++) begin
            if (!(k == 0 && c == 0)) @(negedge clk);
            if (reset) aborted = 1'b1;
            if (c == 0) lvl[k] = tx;
            else if (tx !== lvl[k]) glitch = 1'b1;
          end
        end
        if (!aborted) begin
          for (int k = 0; k < 8; k++) rx[k] = lvl[k+1];
          frames++;
          start_q.push_back(s);
          chk("start_bit", 32'(lvl[0]), 32'd0);
          chk("stop_bit", 32'(lvl[9]), 32'd1);
          chk("bit_stable", 32'(glitch), 32'd0);
          chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          e0, e1, ei, f0, s1, s2;
    logic [31:0] d;
    logic        h;
    reset = 1'b1; we = 1'b0; a = '0; wd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    bus_rd(BASE + 32'h4, d, h);
    chk("rst_status", d, 32'h4);
    chk("status_hit", 32'(h), 32'd1);
    bus_rd(BASE + 32'h8, d, h);
    chk("rst_baud", d, 32'd9);
    bus_rd(BASE, d, h);
    chk("txdata_rd", d, 32'd0);

    // Single byte at the reset divider
    f0 = frames;
    exp_q.push_back(8'h55);
    bus_wr(BASE, 32'h55, e0);
    chk("pre_start_tx", 32'(tx), 32'd1);
    wait_until(e0 + 100);
    chk("busy_last_stop", 32'(busy), 32'd1);
    wait_until(e0 + 101);
    chk("busy_fall", 32'(busy), 32'd0);
    wait_frames(f0 + 1, 50);
    chk("single_start", pop_start(), e0 + 1);

    // Back-to-back frames with no idle gap
    f0 = frames;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    bus_wr(BASE, 32'hA5, e0);
    bus_wr(BASE, 32'h3C, e1);
    wait_frames(f0 + 2, 400);
    s1 = pop_start();
    s2 = pop_start();
    chk("b2b_first_start", s1, e0 + 1);
    chk("b2b_gap", s2, s1 + 100);

    // Overflow: six stores into a four-deep FIFO
    f0 = frames;
    e0 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'h10 + 8'(i));
      bus_wr(BASE, 32'h10 + 32'(i), ei);
      if (i == 0) e0 = ei;
    end
    bus_rd(BASE + 32'h4, d, h);
    chk("ovf_status", d, 32'h4B);
    bus_wr(BASE + 32'h4, 32'h8, e1);
    bus_rd(BASE + 32'h4, d, h);
    chk("ovf_clear", d, 32'h43);
    wait_frames(f0 + 5, 700);
    wait_until(cyc + 200);
    chk("ovf_frames", frames, f0 + 5);
    chk("ovf_first_start", pop_start(), e0 + 1);
    chk("ovf_sb_drained", exp_q.size(), 0);
    start_q.delete();

    // Divider of zero: one clock per bit
    bus_wr(BASE + 32'h8, 32'h0, e1);
    cur_div = 0;
    bus_rd(BASE + 32'h8, d, h);
    chk("baud0_rd", d, 32'h0);
    f0 = frames;
    exp_q.push_back(8'h41);
    bus_wr(BASE, 32'h41, e0);
    wait_until(e0 + 10);
    chk("fast_busy", 32'(busy), 32'd1);
    wait_until(e0 + 11);
    chk("fast_done", 32'(busy), 32'd0);
    wait_frames(f0 + 1, 50);
    chk("fast_start", pop_start(), e0 + 1);

    // Reset during the third data bit of a queued pair
    bus_wr(BASE + 32'h8, 32'd9, e1);
    cur_div = 9;
    f0 = frames;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    bus_wr(BASE, 32'h00, e0);
    bus_wr(BASE, 32'hFF, e1);
    wait_until(e0 + 32);
    chk("pre_rst_tx", 32'(tx), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_tx", 32'(tx), 32'd1);
    bus_rd(BASE + 32'h4, d, h);
    chk("rst_mid_status", d, 32'h4);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    wait_until(cyc + 300);
    chk("rst_no_frames", frames, f0);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    start_q.delete();

    // Stores outside the decoded registers
    f0 = frames;
    we = 1'b1; a = BASE + 32'hC; wd = 32'hFF;
    #2;
    chk("miss_c_hit", 32'(hit), 32'd0);
    chk("miss_c_rd", rd, 32'd0);
    @(posedge clk); #1;
    a = BASE + 32'h10;
    #2;
    chk("miss_10_hit", 32'(hit), 32'd0);
    chk("miss_10_rd", rd, 32'd0);
    @(posedge clk); #1;
    we = 1'b0; a = '0; wd = '0;
    wait_until(cyc + 30);
    chk("miss_tx", 32'(tx), 32'd1);
    chk("miss_busy", 32'(busy), 32'd0);
    bus_rd(BASE + 32'h4, d, h);
    chk("miss_status", d, 32'h4);
    chk("miss_frames", frames, f0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds to the processor's data-memory store/load port (MemWrite / DataAdr / WriteData / ReadData). It decodes a small register window, queues bytes written by software into a FIFO, and serializes them as 8N1 frames on a single `tx` line. The block sits beside `dmem` in `top`. Its `hit` output selects its read data over memory.

## Interface
- `BASE`, 32'h0000_0400: word-aligned base address of the 16-byte register window.
- `DEPTH`, 4: FIFO depth in bytes; power of two, ≥2.
- `DIV_RESET`, 16'd9: reset value of BAUDDIV. Bit time is BAUDDIV+1 clocks.

Ports:
- `clk`  in  1: the only clock. Everything is clocked on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `we`  in  1: store strobe (MemWrite).
- `a`  in  32: byte address (DataAdr). The block decodes only `a[31:2]`.
- `wd`  in  32: store data (WriteData).
- `rd`  out  32: combinational read data. It is 0 when `hit`=0.
- `hit`  out  1: combinational; 1 when `a[31:4]==BASE[31:4]` and `a[3:2]`≠3.
- `tx`  out  1: registered serial output. Idle level is 1.
- `busy`  out  1: combinational; 1 when the FSM is not in IDLE or the FIFO is not empty.

## Operation
Register map (offset, access, contents):
- 0x0 TXDATA (W). A write pushes `wd[7:0]` into the FIFO. A read returns 0.
- 0x4 STATUS (R/W1C). Bit 0 is busy, bit 1 is FIFO full, bit 2 is FIFO empty, bit 3 is overflow (sticky), and bits [7:4] hold the FIFO count. A write with `wd[3]`=1 clears overflow. Other written bits are ignored.
- 0x8 BAUDDIV (R/W). Bits [15:0] are the divider. Bits [31:16] read as 0.

FIFO behaviour:
- A push while full, with no pop in the same cycle, is dropped and sets overflow.
- A push and a pop in the same cycle are both honored, including when the FIFO is full.
- If an overflow set and a W1C clear happen in the same cycle, the set wins.

FSM states are IDLE, START, DATA and STOP.
- IDLE: `tx`=1. If the FIFO is not empty, pop into an 8-bit shift register, load the bit counter with BAUDDIV, and move to START.
- START: `tx`=0 for BAUDDIV+1 cycles, then go to DATA with bit index 0.
- DATA: `tx`=shift[0] for BAUDDIV+1 cycles, then shift right. After 8 bits (LSB first), go to STOP.
- STOP: `tx`=1 for BAUDDIV+1 cycles. At the end, if the FIFO is not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.

Arithmetic and width rules:
- The bit counter is 16-bit and counts down. It reloads from the current BAUDDIV at every bit boundary.
- A BAUDDIV write during a frame takes effect at the next bit boundary.
- BAUDDIV=0 gives 1 clock per bit.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits and saturates at DEPTH.
- Writes to offset 0xC or outside the window have no effect.

## Timing
Reset values:
- `tx`=1, state IDLE, FIFO empty, overflow=0, BAUDDIV=DIV_RESET.
- Hence `busy`=0 and STATUS reads 0x4.

Reset mid-frame:
- The frame is aborted and `tx` is 1 from the first edge with `reset`=1.
- Queued bytes are discarded.

Latency:
- A TXDATA write committed at edge E0 into an empty FIFO with the FSM in IDLE is popped at E1.
- `tx` goes to 0 after E1.
- One frame lasts 10×(BAUDDIV+1) cycles.
- `busy` falls the cycle after STOP completes with the FIFO empty.

Read timing:
- Reads are combinational, same cycle, like `dmem`.
- A STATUS read reflects state before the current edge's update.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_state_t` (IDLE/START/DATA/STOP);
  - the register offsets `TXDATA_OFS`, `STATUS_OFS`, `BAUDDIV_OFS`;
  - the STATUS bit-index constants.
- Sub-module `sync_fifo #(WIDTH, DEPTH)` provides push, pop, full, empty and count.
- The top-level `mmio_uart_tx` holds the address decode, the registers, the FSM and the shifter.

## Test plan
- **Single byte.** Reset, then write 0x55 to BASE with DIV_RESET=9. Required: `tx` stays 1 until E1. It then carries 0,1,0,1,0,1,0,1,0,1, each level held 10 cycles. `busy` falls 100 cycles after E1.
- **Back-to-back.** Write 0xA5 then 0x3C on consecutive cycles. Required: the second start bit begins on the cycle after the first stop bit ends, with 200 cycles of continuous framing. Data bits are LSB first: 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- **Overflow.** Write 6 bytes on cycles E0 to E5 with DEPTH=4. Required:
  - The first byte is popped at E1, and the 6th byte is dropped.
  - STATUS reads full=1, overflow=1, count=4 after E5.
  - Exactly 5 frames are sent.
  - Writing 0x8 to STATUS clears overflow.
- **Baud change.** Write 0 to BASE+8, then 0x41 to BASE. Required: each bit lasts 1 cycle and the frame is 10 cycles. Reading BASE+8 returns 0.
- **Reset mid-frame.** Queue 0x00 and 0xFF, then assert `reset` during the third data bit. Required: `tx`=1 from that edge, and STATUS reads 0x4. No further frames are sent after `reset` is deasserted.
- **Address miss.** Store to BASE+0xC and to BASE+0x10. Required: `hit`=0, `rd`=0, and no FIFO push. The stores leave `tx` idle and overflow unchanged.
